// File: rtl/rc4_prga_decrypt.sv
// -----------------------------------------------------------------------------
// rc4_prga_decrypt
//   RC4 keystream generator (PRGA) plus decrypt stage. It runs after the key
//   schedule has filled s_memory for one candidate key. Each ciphertext byte
//   from e_memory is XORed with the keystream and the result is written to
//   d_memory. Every plaintext byte is also checked to be lowercase 'a'..'z'
//   or space, so the key-search controller can accept or reject the key from
//   pass/done.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   start          level start; only looked at in IDLE and DONE
//   done, pass     done is high while in DONE; pass is valid when done=1
//   s_addr/s_data/s_wren/s_q   s_memory port (s_q has 1-cycle read latency)
//   e_addr/e_q                 ciphertext memory (e_q has 1-cycle latency)
//   d_addr/d_data/d_wren       plaintext memory write port
//
// State table
//   IDLE    | waiting for start
//   RD_I    | i <= i+1, present s_addr = i+1
//   LATCH_I | si <= s[i], j <= j + s[i]
//   RD_J    | present s_addr = j
//   LATCH_J | sj <= s[j]
//   WR_I    | s[i] <= sj
//   WR_J    | s[j] <= si
//   RD_F    | present s_addr = si + sj
//   LATCH_F | f <= keystream byte, c <= ciphertext byte
//   WR_D    | write f^c to d[k], check it, advance or finish
//   DONE    | done=1, pass held; start restarts
// -----------------------------------------------------------------------------
module rc4_prga_decrypt #(
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 5,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic              pass,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] e_addr,
  input  logic [7:0]        e_q,
  output logic [ADDR_W-1:0] d_addr,
  output logic [7:0]        d_data,
  output logic              d_wren
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] RD_I    = 4'd1;
  localparam logic [3:0] LATCH_I = 4'd2;
  localparam logic [3:0] RD_J    = 4'd3;
  localparam logic [3:0] LATCH_J = 4'd4;
  localparam logic [3:0] WR_I    = 4'd5;
  localparam logic [3:0] WR_J    = 4'd6;
  localparam logic [3:0] RD_F    = 4'd7;
  localparam logic [3:0] LATCH_F = 4'd8;
  localparam logic [3:0] WR_D    = 4'd9;
  localparam logic [3:0] DONE    = 4'd10;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

  logic [3:0]        r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [ADDR_W-1:0] r_k;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_f;
  logic [7:0]        r_c;
  logic              r_pass;

  logic [7:0]        w_pt;
  logic              w_valid;

  assign w_pt    = r_f ^ r_c;
  assign w_valid = (w_pt == 8'h20) || ((w_pt >= 8'h61) && (w_pt <= 8'h7A));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_i     <= 8'd0;
      r_j     <= 8'd0;
      r_k     <= '0;
      r_si    <= 8'd0;
      r_sj    <= 8'd0;
      r_f     <= 8'd0;
      r_c     <= 8'd0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_k     <= '0;
            r_pass  <= 1'b0;
            r_state <= RD_I;
          end
        end
        RD_I: begin
          r_i     <= r_i + 8'd1;
          r_state <= LATCH_I;
        end
        LATCH_I: begin
          r_si    <= s_q;
          r_j     <= r_j + s_q;
          r_state <= RD_J;
        end
        RD_J:    r_state <= LATCH_J;
        LATCH_J: begin
          r_sj    <= s_q;
          r_state <= WR_I;
        end
        WR_I:    r_state <= WR_J;
        WR_J:    r_state <= RD_F;
        RD_F:    r_state <= LATCH_F;
        LATCH_F: begin
          r_f     <= s_q;
          r_c     <= e_q;
          r_state <= WR_D;
        end
        WR_D: begin
          if (!w_valid && CHECK_EN) begin
            r_pass  <= 1'b0;
            r_state <= DONE;
          end else if (r_k == K_LAST) begin
            r_pass  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= RD_I;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory controls decode straight from state so the address sits on the
  // bus during the state that names it and data returns one state later.
  always_comb begin
    s_addr = 8'd0;
    s_data = 8'd0;
    s_wren = 1'b0;
    d_data = 8'd0;
    d_wren = 1'b0;
    case (r_state)
      RD_I: s_addr = r_i + 8'd1;
      RD_J: s_addr = r_j;
      WR_I: begin
        s_addr = r_i;
        s_data = r_sj;
        s_wren = 1'b1;
      end
      WR_J: begin
        s_addr = r_j;
        s_data = r_si;
        s_wren = 1'b1;
      end
      RD_F: s_addr = r_si + r_sj;
      WR_D: begin
        d_data = w_pt;
        d_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign e_addr = r_k;
  assign d_addr = r_k;
  assign done   = (r_state == DONE);
  assign pass   = r_pass;

endmodule
